// File: rtl/fetch_stage_pkg.sv
// Shared core definitions: datapath width, bubble instruction and fetch FSM encoding.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; a bubble request overrides a stall, reset loads a bubble.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] BUBBLE_INSTR = NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_bubble,
  input  logic            i_stall,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pc4,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc4,
  output logic            o_valid
);

  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc4;
  logic            r_valid;

  always_ff @(posedge clk) begin
    if (!rst_n || i_bubble) begin
      r_instr <= BUBBLE_INSTR;
      r_pc    <= '0;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (!i_stall) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_pc4   <= i_pc4;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_pc4   = r_pc4;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection, BOOT/RUN/HALT control and IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stallF,
  input  logic            stallD,
  input  logic            flushD,
  input  logic            PCSE,
  input  logic [XLEN-1:0] pc_targetE,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instrD,
  output logic [XLEN-1:0] pcD,
  output logic [XLEN-1:0] pc4D,
  output logic            validD,
  output logic            fetch_fault
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_pc_plus4;
  logic            r_fault;
  logic            w_fault_nxt;
  logic            w_bubble;

  assign w_pc_plus4 = r_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_fault_nxt = r_fault;
    case (r_state)
      BOOT: w_state_nxt = RUN;
      RUN: begin
        // Redirect wins over stallF; a misaligned target freezes the PC and halts fetch.
        if (PCSE) begin
          if (pc_targetE[1:0] != 2'b00) begin
            w_state_nxt = HALT;
            w_fault_nxt = 1'b1;
          end else begin
            w_pc_nxt = pc_targetE;
          end
        end else if (!stallF) begin
          w_pc_nxt = w_pc_plus4;
        end
      end
      HALT: w_state_nxt = HALT;
      default: w_state_nxt = BOOT;
    endcase
  end

  assign w_bubble    = (r_state != RUN) || flushD;
  assign imem_addr   = r_pc;
  assign fetch_fault = r_fault;

  if_id_reg #(
    .BUBBLE_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_bubble(w_bubble),
    .i_stall (stallD),
    .i_instr (imem_rdata),
    .i_pc    (r_pc),
    .i_pc4   (w_pc_plus4),
    .o_instr (instrD),
    .o_pc    (pcD),
    .o_pc4   (pc4D),
    .o_valid (validD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage; memory returns address+0x100 for every word.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n, stallF, stallD, flushD, PCSE;
  logic [31:0] pc_targetE, imem_addr, imem_rdata, instrD, pcD, pc4D;
  logic        validD, fetch_fault;

  logic        rst2_n;
  logic [31:0] imem_addr2, imem_rdata2, instrD2, pcD2, pc4D2;
  logic        validD2, fetch_fault2;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  assign imem_rdata  = imem_addr + 32'h100;
  assign imem_rdata2 = imem_addr2 + 32'h100;

  fetch_stage u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stallF     (stallF),
    .stallD     (stallD),
    .flushD     (flushD),
    .PCSE       (PCSE),
    .pc_targetE (pc_targetE),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .instrD     (instrD),
    .pcD        (pcD),
    .pc4D       (pc4D),
    .validD     (validD),
    .fetch_fault(fetch_fault)
  );

  fetch_stage #(
    .RESET_PC(32'hFFFF_FFF8)
  ) u_dut_wrap (
    .clk        (clk),
    .rst_n      (rst2_n),
    .stallF     (1'b0),
    .stallD     (1'b0),
    .flushD     (1'b0),
    .PCSE       (1'b0),
    .pc_targetE (32'h0),
    .imem_addr  (imem_addr2),
    .imem_rdata (imem_rdata2),
    .instrD     (instrD2),
    .pcD        (pcD2),
    .pc4D       (pc4D2),
    .validD     (validD2),
    .fetch_fault(fetch_fault2)
  );

  typedef struct {
    logic        rst_n, stallF, stallD, flushD, PCSE;
    logic [31:0] tgt;
    logic [31:0] addr, instr, pc, pc4;
    logic        valid, fault;
  } vec_t;

  localparam int unsigned NV = 26;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic r, input logic sf, input logic sd, input logic fd,
                              input logic ps, input logic [31:0] tg, input logic [31:0] ad,
                              input logic [31:0] in, input logic [31:0] p, input logic [31:0] p4,
                              input logic v, input logic f);
    vec_t t;
    t.rst_n = r; t.stallF = sf; t.stallD = sd; t.flushD = fd; t.PCSE = ps; t.tgt = tg;
    t.addr = ad; t.instr = in; t.pc = p; t.pc4 = p4; t.valid = v; t.fault = f;
    return t;
  endfunction

  task automatic chk(input string name, input int unsigned idx, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int unsigned idx, input logic [31:0] ad, input logic [31:0] in,
                         input logic [31:0] p, input logic [31:0] p4, input logic v,
                         input logic f, input logic use_wrap);
    n_vec++;
    if (use_wrap) begin
      chk("wrap_addr", idx, imem_addr2, ad);
      chk("wrap_instr", idx, instrD2, in);
      chk("wrap_pcD", idx, pcD2, p);
      chk("wrap_pc4D", idx, pc4D2, p4);
      chk("wrap_valid", idx, {31'b0, validD2}, {31'b0, v});
      chk("wrap_fault", idx, {31'b0, fetch_fault2}, {31'b0, f});
    end else begin
      chk("imem_addr", idx, imem_addr, ad);
      chk("instrD", idx, instrD, in);
      chk("pcD", idx, pcD, p);
      chk("pc4D", idx, pc4D, p4);
      chk("validD", idx, {31'b0, validD}, {31'b0, v});
      chk("fetch_fault", idx, {31'b0, fetch_fault}, {31'b0, f});
    end
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    // rst sF sD fD PCSE tgt | addr instr pcD pc4D valid fault
    vecs[0]  = mk(0,0,0,0,0,32'h0,   32'h0,  NOP,        32'h0,  32'h0,  0,0);
    vecs[1]  = mk(0,0,0,0,0,32'h0,   32'h0,  NOP,        32'h0,  32'h0,  0,0);
    vecs[2]  = mk(1,0,0,0,0,32'h0,   32'h0,  NOP,        32'h0,  32'h0,  0,0);
    vecs[3]  = mk(1,0,0,0,0,32'h0,   32'h4,  32'h100,    32'h0,  32'h4,  1,0);
    vecs[4]  = mk(1,0,0,0,0,32'h0,   32'h8,  32'h104,    32'h4,  32'h8,  1,0);
    vecs[5]  = mk(1,1,1,0,0,32'h0,   32'h8,  32'h104,    32'h4,  32'h8,  1,0);
    vecs[6]  = mk(1,1,1,0,0,32'h0,   32'h8,  32'h104,    32'h4,  32'h8,  1,0);
    vecs[7]  = mk(1,1,1,0,0,32'h0,   32'h8,  32'h104,    32'h4,  32'h8,  1,0);
    vecs[8]  = mk(1,0,0,0,0,32'h0,   32'hC,  32'h108,    32'h8,  32'hC,  1,0);
    vecs[9]  = mk(1,0,0,0,0,32'h0,   32'h10, 32'h10C,    32'hC,  32'h10, 1,0);
    vecs[10] = mk(1,0,0,1,1,32'h40,  32'h40, NOP,        32'h0,  32'h0,  0,0);
    vecs[11] = mk(1,0,0,0,0,32'h0,   32'h44, 32'h140,    32'h40, 32'h44, 1,0);
    vecs[12] = mk(1,1,1,1,1,32'h80,  32'h80, NOP,        32'h0,  32'h0,  0,0);
    vecs[13] = mk(1,0,0,0,0,32'h0,   32'h84, 32'h180,    32'h80, 32'h84, 1,0);
    vecs[14] = mk(1,0,1,0,0,32'h0,   32'h88, 32'h180,    32'h80, 32'h84, 1,0);
    vecs[15] = mk(1,0,0,1,0,32'h0,   32'h8C, NOP,        32'h0,  32'h0,  0,0);
    vecs[16] = mk(1,1,0,0,0,32'h0,   32'h8C, 32'h18C,    32'h8C, 32'h90, 1,0);
    vecs[17] = mk(1,0,0,1,1,32'h42,  32'h8C, NOP,        32'h0,  32'h0,  0,1);
    vecs[18] = mk(1,0,0,0,0,32'h0,   32'h8C, NOP,        32'h0,  32'h0,  0,1);
    vecs[19] = mk(1,0,0,0,1,32'h100, 32'h8C, NOP,        32'h0,  32'h0,  0,1);
    vecs[20] = mk(0,1,1,0,1,32'h200, 32'h0,  NOP,        32'h0,  32'h0,  0,0);
    vecs[21] = mk(1,0,0,0,0,32'h0,   32'h0,  NOP,        32'h0,  32'h0,  0,0);
    vecs[22] = mk(1,0,0,0,0,32'h0,   32'h4,  32'h100,    32'h0,  32'h4,  1,0);
    vecs[23] = mk(0,1,1,0,0,32'h0,   32'h0,  NOP,        32'h0,  32'h0,  0,0);
    vecs[24] = mk(1,0,0,0,0,32'h0,   32'h0,  NOP,        32'h0,  32'h0,  0,0);
    vecs[25] = mk(1,0,0,0,0,32'h0,   32'h4,  32'h100,    32'h0,  32'h4,  1,0);

    rst2_n = 1'b0;
    for (int unsigned i = 0; i < NV; i++) begin
      rst_n      = vecs[i].rst_n;
      stallF     = vecs[i].stallF;
      stallD     = vecs[i].stallD;
      flushD     = vecs[i].flushD;
      PCSE       = vecs[i].PCSE;
      pc_targetE = vecs[i].tgt;
      @(posedge clk);
      #1;
      chk_all(i, vecs[i].addr, vecs[i].instr, vecs[i].pc, vecs[i].pc4, vecs[i].valid,
              vecs[i].fault, 1'b0);
    end

    // PC wrap-around on the RESET_PC=FFFF_FFF8 instance
    chk_all(100, 32'hFFFF_FFF8, NOP, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    rst2_n = 1'b1;
    @(posedge clk); #1;
    chk_all(101, 32'hFFFF_FFF8, NOP, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk_all(102, 32'hFFFF_FFFC, 32'h0000_00F8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk_all(103, 32'h0000_0000, 32'h0000_00FC, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk_all(104, 32'h0000_0004, 32'h0000_0100, 32'h0000_0000, 32'h0000_0004, 1'b1, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013: addi x0,x0,0, inserted on flush/bubble.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 stallF  input  1  hold PC (load-use stall from hazard unit).
REQ-006 stallD  input  1  hold IF/ID register.
REQ-007 flushD  input  1  replace IF/ID contents with bubble.
REQ-008 PCSE  input  1  redirect request from execute (taken branch/jump).
REQ-009 pc_targetE  input  32  redirect target address.
REQ-010 imem_addr  output  32  instruction memory address, equal to the current PC.
REQ-011 imem_rdata  input  32  instruction word, combinational read of imem_addr.
REQ-012 instrD  output  32  registered instruction to decode.
REQ-013 pcD  output  32  registered PC of instrD.
REQ-014 pc4D  output  32  registered pcD+4.
REQ-015 validD  output  1  instrD is a real fetched instruction, not a bubble.
REQ-016 fetch_fault  output  1  sticky misaligned-redirect fault.

Function
REQ-017 The FSM SHALL have states BOOT, RUN and HALT.
REQ-018 BOOT: entered on reset; for exactly one cycle the IF/ID register loads a bubble and the PC holds RESET_PC; then go to RUN.
REQ-019 RUN: the PC SHALL update each cycle as follows: PCSE -> pc_targetE; else stallF -> hold; else PC+4, with 32-bit wrap-around (32'hFFFF_FFFC+4 = 0).
REQ-020 PCSE SHALL take priority over stallF when both are asserted in the same cycle.
REQ-021 If PCSE is asserted with pc_targetE[1:0] != 0 in RUN, the PC SHALL hold, fetch_fault SHALL set, and the FSM SHALL go to HALT.
REQ-022 HALT: the PC holds and IF/ID loads a bubble every cycle; the only exit is reset.
REQ-023 IF/ID update priority: (HALT or BOOT or flushD) -> bubble; else stallD -> hold; else load {imem_rdata, PC, PC+4, validD=1}.
REQ-024 flushD SHALL override stallD when both are asserted.
REQ-025 A bubble SHALL be instrD=NOP_INSTR, validD=0, and pcD/pc4D=0.
REQ-026 Latency: the instruction at PC appears on instrD exactly one cycle after imem_addr=PC, absent stallD/flushD.
REQ-027 After a redirect, the first target instruction SHALL appear on instrD two cycles after PCSE is sampled (one bubble).
REQ-028 imem_addr SHALL be driven directly from the PC register; there is no combinational path from any input to imem_addr.

Reset
REQ-029 When rst_n is sampled low: PC=RESET_PC, FSM=BOOT, fetch_fault=0, and IF/ID holds a bubble.
REQ-030 Reset SHALL override stall, flush and PCSE in the same cycle, including reset asserted mid-stall or while in HALT.

Structure
REQ-031 The state encoding (2-bit enum BOOT/RUN/HALT), NOP_INSTR and the instruction/PC width constant (32) SHALL live in the shared core package.
REQ-032 One sub-module, if_id_reg (the IF/ID pipeline register with stall/flush/bubble), is natural; the PC register, next-PC logic and FSM stay in fetch_stage.

Verification
REQ-033 Reset, then release with memory word at address A = 32'h(A+0x100): the cycle after release gives validD=0 and instrD=0x13; the next cycles give pcD=0,4,8 with instrD=0x100,0x104,0x108 and validD=1.
REQ-034 stallF=stallD=1 for 3 cycles at PC=8: imem_addr stays 8, instrD/pcD are unchanged; after release the sequence resumes at pcD=8 with no instruction lost or duplicated.
REQ-035 PCSE=1, flushD=1, pc_targetE=0x40 at PC=0x10: the next cycle gives imem_addr=0x40 and validD=0; the cycle after gives pcD=0x40.
REQ-036 PCSE=1 and stallF=1 together, target 0x80: the PC takes 0x80 (redirect wins); flushD=1 with stallD=1 gives a bubble.
REQ-037 PCSE=1 with pc_targetE=0x42: fetch_fault=1, the FSM is in HALT, and validD stays 0 until rst_n=0, which clears the fault and restarts at RESET_PC.
REQ-038 PC preloaded near 32'hFFFF_FFF8 (RESET_PC override): the PC sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
